// File: rtl/cvxif_compressed_arbiter_if.sv
// Bundle of lane-side and CV-X-IF compressed-channel signals for cvxif_compressed_arbiter.
// The arbiter connects through the slave modport; the surrounding ID stage uses master.
interface cvxif_compressed_arbiter_if #(
  parameter int unsigned NrLanes = 1,
  parameter int unsigned XLEN    = 64
);
  logic                    flush_i;
  logic [XLEN-1:0]         hart_id_i;
  logic [NrLanes-1:0]      lane_valid_i;
  logic [NrLanes*32-1:0]   lane_instr_i;
  logic [NrLanes-1:0]      lane_is_cmp_i;
  logic [NrLanes-1:0]      lane_illegal_i;
  logic [NrLanes-1:0]      lane_ack_i;
  logic [NrLanes-1:0]      lane_done_o;
  logic [NrLanes*32-1:0]   lane_instr_o;
  logic [NrLanes-1:0]      lane_illegal_o;
  logic                    stall_o;
  logic                    cmp_valid_o;
  logic [15:0]             cmp_instr_o;
  logic [XLEN-1:0]         cmp_hartid_o;
  logic                    cmp_ready_i;
  logic                    cmp_accept_i;
  logic [31:0]             cmp_resp_instr_i;

  modport slave (
    input  flush_i, hart_id_i, lane_valid_i, lane_instr_i, lane_is_cmp_i, lane_illegal_i,
           lane_ack_i, cmp_ready_i, cmp_accept_i, cmp_resp_instr_i,
    output lane_done_o, lane_instr_o, lane_illegal_o, stall_o, cmp_valid_o, cmp_instr_o,
           cmp_hartid_o
  );

  modport master (
    output flush_i, hart_id_i, lane_valid_i, lane_instr_i, lane_is_cmp_i, lane_illegal_i,
           lane_ack_i, cmp_ready_i, cmp_accept_i, cmp_resp_instr_i,
    input  lane_done_o, lane_instr_o, lane_illegal_o, stall_o, cmp_valid_o, cmp_instr_o,
           cmp_hartid_o
  );
endinterface

// File: rtl/cvxif_compressed_arbiter.sv
// Shares the CV-X-IF compressed request channel between ID decode lanes and stalls fetch until
// each valid lane is resolved. Optional REQ timeout is enabled with `define CVXIF_CMP_TIMEOUT_EN.
module cvxif_compressed_arbiter #(
  parameter int unsigned NrLanes    = 1,
  parameter int unsigned XLEN       = 64,
  parameter int unsigned TimeoutCyc = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic [1:0]             state_o,
  cvxif_compressed_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  if (NrLanes < 1 || NrLanes > 2) begin : g_bad_lanes
    $error("NrLanes must be 1 or 2");
  end
  if (TimeoutCyc < 1 || TimeoutCyc > 255) begin : g_bad_timeout
    $error("TimeoutCyc must lie within the 8-bit counter range 1..255");
  end

  logic [1:0]            state_q;
  logic                  grant_q, grant_d;
  logic [15:0]           instr_q;
  logic [XLEN-1:0]       hartid_q;
  logic [NrLanes-1:0]    done_q, res_illegal_q;
  logic [NrLanes*32-1:0] res_instr_q;
  logic [NrLanes-1:0]    offload_cand, pending, done_vec;
  logic                  sel_valid;
  logic [31:0]           sel_instr;
  logic [15:0]           new_instr;
  logic                  resp_fire, timeout_fire, set_done, set_illegal;
  logic [31:0]           set_instr;

  assign offload_cand = bus.lane_is_cmp_i & bus.lane_illegal_i;
  assign pending      = bus.lane_valid_i & offload_cand & ~done_q;

  // Lane 1 is granted only when lane 0 is not pending, keeping program order.
  if (NrLanes == 1) begin : g_one_lane
    assign grant_d = 1'b0;
  end else begin : g_two_lanes
    assign grant_d = ~pending[0];
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_instr = '0;
    new_instr = '0;
    for (int i = 0; i < NrLanes; i++) begin
      if (grant_q == 1'(i)) begin
        sel_valid = bus.lane_valid_i[i];
        sel_instr = bus.lane_instr_i[i*32 +: 32];
      end
      if (grant_d == 1'(i)) new_instr = bus.lane_instr_i[i*32 +: 16];
    end
  end

`ifdef CVXIF_CMP_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TimeoutCyc - 1);
  logic [7:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              cnt_q <= '0;
    else if (state_q != REQ)  cnt_q <= '0;
    else if (cnt_q != 8'hFF)  cnt_q <= cnt_q + 8'd1;
  end

  assign timeout_fire = (state_q == REQ) && !bus.cmp_ready_i && !bus.flush_i && (cnt_q == TO_LAST);
`else
  assign timeout_fire = 1'b0;
`endif

  // A dropped lane (sel_valid low) still completes the handshake but its result is discarded.
  assign resp_fire   = (state_q == REQ) && bus.cmp_ready_i && !bus.flush_i;
  assign set_done    = (resp_fire || timeout_fire) && sel_valid;
  assign set_illegal = !(resp_fire && bus.cmp_accept_i);
  assign set_instr   = set_illegal ? sel_instr : bus.cmp_resp_instr_i;

  // Channel handshake: cmp_valid_o rises on a grant and is never retracted; cmp_instr_o and
  // cmp_hartid_o stay stable until the cycle cmp_ready_i is high, which is the transfer cycle and
  // also carries cmp_accept_i / cmp_resp_instr_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      instr_q  <= '0;
      hartid_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (!bus.flush_i && (|pending)) begin
          state_q  <= REQ;
          grant_q  <= grant_d;
          instr_q  <= new_instr;
          hartid_q <= bus.hart_id_i;
        end
        REQ: begin
          if (bus.flush_i)          state_q <= bus.cmp_ready_i ? IDLE : DRAIN;
          else if (bus.cmp_ready_i) state_q <= IDLE;
          else if (timeout_fire)    state_q <= DRAIN;
        end
        DRAIN: if (bus.cmp_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q        <= '0;
      res_illegal_q <= '0;
      res_instr_q   <= '0;
    end else begin
      for (int i = 0; i < NrLanes; i++) begin
        if (bus.flush_i || bus.lane_ack_i[i]) begin
          done_q[i]               <= 1'b0;
          res_illegal_q[i]        <= 1'b0;
          res_instr_q[i*32 +: 32] <= '0;
        end
        if (set_done && !bus.flush_i && (grant_q == 1'(i))) begin
          done_q[i]               <= 1'b1;
          res_illegal_q[i]        <= set_illegal;
          res_instr_q[i*32 +: 32] <= set_instr;
        end
      end
    end
  end

  always_comb begin
    done_vec           = '0;
    bus.lane_instr_o   = '0;
    bus.lane_illegal_o = '0;
    for (int i = 0; i < NrLanes; i++) begin
      done_vec[i] = rst_ni & (done_q[i] | (bus.lane_valid_i[i] & ~offload_cand[i]));
      if (rst_ni) begin
        bus.lane_instr_o[i*32 +: 32] = done_q[i] ? res_instr_q[i*32 +: 32] : bus.lane_instr_i[i*32 +: 32];
        bus.lane_illegal_o[i]        = done_q[i] ? res_illegal_q[i] : bus.lane_illegal_i[i];
      end
    end
  end

  assign bus.lane_done_o  = done_vec;
  assign bus.stall_o      = rst_ni & ~bus.flush_i & (|(bus.lane_valid_i & ~done_vec));
  assign bus.cmp_valid_o  = (state_q != IDLE);
  assign bus.cmp_instr_o  = instr_q;
  assign bus.cmp_hartid_o = hartid_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_cvxif_compressed_arbiter.sv
// Directed bench for cvxif_compressed_arbiter (two lanes, TimeoutCyc=4) with a reference model
// checked every cycle plus hand-computed expectations per scenario.
module tb_cvxif_compressed_arbiter;
  localparam int NL = 2;
  localparam int XL = 64;
  localparam int TO = 4;
`ifdef CVXIF_CMP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [1:0] state;
  int         n_checks = 0;
  int         n_errors = 0;

  cvxif_compressed_arbiter_if #(.NrLanes(NL), .XLEN(XL)) bus ();

  cvxif_compressed_arbiter #(.NrLanes(NL), .XLEN(XL), .TimeoutCyc(TO)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .state_o (state),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mode;   // 0 no request, 1 request open, 2 draining an abandoned request
  int          m_lane;
  int          m_age;
  logic [15:0] m_req_instr;
  logic [63:0] m_req_hart;
  logic        m_done[NL];
  logic [31:0] m_res_instr[NL];
  logic        m_res_ill[NL];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_mode = 0; m_lane = 0; m_age = 0; m_req_instr = '0; m_req_hart = '0;
      for (int i = 0; i < NL; i++) begin m_done[i] = 0; m_res_instr[i] = '0; m_res_ill[i] = 0; end
    end else begin : upd
      logic        pend[NL];
      bit          set_any;
      logic [31:0] s_instr;
      logic        s_ill;
      set_any = 0; s_instr = '0; s_ill = 0;
      for (int i = 0; i < NL; i++)
        pend[i] = bus.lane_valid_i[i] & bus.lane_is_cmp_i[i] & bus.lane_illegal_i[i] & !m_done[i];
      case (m_mode)
        0: if (!bus.flush_i && (pend[0] || pend[1])) begin
          m_lane = pend[0] ? 0 : 1;
          m_mode = 1; m_age = 0;
          m_req_instr = bus.lane_instr_i[m_lane*32 +: 16];
          m_req_hart  = bus.hart_id_i;
        end
        1: begin
          if (bus.flush_i) m_mode = bus.cmp_ready_i ? 0 : 2;
          else if (bus.cmp_ready_i) begin
            set_any = bus.lane_valid_i[m_lane];
            s_ill   = !bus.cmp_accept_i;
            s_instr = bus.cmp_accept_i ? bus.cmp_resp_instr_i : bus.lane_instr_i[m_lane*32 +: 32];
            m_mode  = 0;
          end else begin
            m_age++;
            if (TO_EN && m_age == TO) begin
              set_any = bus.lane_valid_i[m_lane];
              s_ill = 1; s_instr = bus.lane_instr_i[m_lane*32 +: 32];
              m_mode = 2;
            end
          end
        end
        default: if (bus.cmp_ready_i) m_mode = 0;
      endcase
      for (int i = 0; i < NL; i++)
        if (bus.flush_i || bus.lane_ack_i[i]) begin m_done[i] = 0; m_res_instr[i] = '0; m_res_ill[i] = 0; end
      if (set_any) begin m_done[m_lane] = 1; m_res_instr[m_lane] = s_instr; m_res_ill[m_lane] = s_ill; end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk_i) begin : cmp
    logic [1:0] e_done;
    logic       direct;
    if (!rst_ni) begin
      chk("rst_cmp_valid", bus.cmp_valid_o, 0);
      chk("rst_lane_done", bus.lane_done_o, 0);
      chk("rst_stall", bus.stall_o, 0);
      chk("rst_lane_instr", bus.lane_instr_o, 0);
    end else begin
      for (int i = 0; i < NL; i++) begin
        direct    = bus.lane_valid_i[i] & ~(bus.lane_is_cmp_i[i] & bus.lane_illegal_i[i]);
        e_done[i] = m_done[i] | direct;
        chk($sformatf("lane_done[%0d]", i), bus.lane_done_o[i], e_done[i]);
        if (e_done[i]) begin
          chk($sformatf("lane_instr[%0d]", i), bus.lane_instr_o[i*32 +: 32],
              m_done[i] ? m_res_instr[i] : bus.lane_instr_i[i*32 +: 32]);
          chk($sformatf("lane_illegal[%0d]", i), bus.lane_illegal_o[i],
              m_done[i] ? m_res_ill[i] : bus.lane_illegal_i[i]);
        end
      end
      chk("stall", bus.stall_o, !bus.flush_i && ((bus.lane_valid_i & ~e_done) != 2'b00));
      chk("cmp_valid", bus.cmp_valid_o, m_mode != 0);
      if (m_mode != 0) begin
        chk("cmp_instr", bus.cmp_instr_o, m_req_instr);
        chk("cmp_hartid", bus.cmp_hartid_o, m_req_hart);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic lanes(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] c, input logic [1:0] il);
    bus.lane_valid_i   = v;
    bus.lane_instr_i   = {i1, i0};
    bus.lane_is_cmp_i  = c;
    bus.lane_illegal_i = il;
  endtask

  task automatic wait_req(input string nm);
    int k;
    k = 0;
    while (bus.cmp_valid_o !== 1'b1 && k < 16) begin step(); k++; end
    chk(nm, bus.cmp_valid_o, 1);
  endtask

  task automatic respond(input logic acc, input logic [31:0] r, input logic [1:0] ack);
    bus.cmp_ready_i = 1; bus.cmp_accept_i = acc; bus.cmp_resp_instr_i = r; bus.lane_ack_i = ack;
    step();
    bus.cmp_ready_i = 0; bus.cmp_accept_i = 0; bus.cmp_resp_instr_i = '0; bus.lane_ack_i = '0;
  endtask

  task automatic ack_and_drop(input logic [1:0] ack);
    bus.lane_ack_i = ack; bus.lane_valid_i = '0;
    step();
    bus.lane_ack_i = '0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bus.flush_i = 0; bus.hart_id_i = '0; bus.lane_ack_i = '0;
    bus.cmp_ready_i = 0; bus.cmp_accept_i = 0; bus.cmp_resp_instr_i = '0;
    lanes(2'b01, 32'h0000_0001, 32'h0, 2'b01, 2'b00);

    // Reset holds every output low even with a legal lane presented.
    @(negedge clk_i);
    chk("reset_done", bus.lane_done_o, 0);
    chk("reset_stall", bus.stall_o, 0);
    chk("reset_state", state, 0);
    step(); step();
    rst_ni = 1;

    // Legal RVC 0x0001: resolved in the same cycle, no request.
    @(negedge clk_i);
    chk("s1_done", bus.lane_done_o, 2'b01);
    chk("s1_instr", bus.lane_instr_o[31:0], 32'h0000_0001);
    chk("s1_stall", bus.stall_o, 0);
    for (int k = 0; k < 3; k++) begin step(); chk("s1_no_req", bus.cmp_valid_o, 0); end
    lanes(2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
    step();

    // Illegal 0x6000 accepted by the coprocessor.
    bus.hart_id_i = 64'hA5;
    lanes(2'b01, 32'h0000_6000, 32'h0, 2'b01, 2'b01);
    @(negedge clk_i);
    chk("s2_stall_c0", bus.stall_o, 1);
    step();
    chk("s2_req", bus.cmp_valid_o, 1);
    chk("s2_req_instr", bus.cmp_instr_o, 16'h6000);
    chk("s2_req_hart", bus.cmp_hartid_o, 64'hA5);
    bus.hart_id_i = 64'h5A;
    step();
    bus.cmp_ready_i = 1; bus.cmp_accept_i = 1; bus.cmp_resp_instr_i = 32'h00A0_0093;
    @(negedge clk_i);
    chk("s2_stall_c2", bus.stall_o, 1);
    chk("s2_hart_stable", bus.cmp_hartid_o, 64'hA5);
    step();
    bus.cmp_ready_i = 0; bus.cmp_accept_i = 0; bus.cmp_resp_instr_i = '0;
    @(negedge clk_i);
    chk("s2_done", bus.lane_done_o, 2'b01);
    chk("s2_instr", bus.lane_instr_o[31:0], 32'h00A0_0093);
    chk("s2_illegal", bus.lane_illegal_o[0], 0);
    chk("s2_stall_c3", bus.stall_o, 0);
    step();
    ack_and_drop(2'b01);

    // Same with accept=0; an ack in the response cycle loses to the set.
    lanes(2'b01, 32'h0000_6000, 32'h0, 2'b01, 2'b01);
    step(); step();
    respond(0, 32'hDEAD_BEEF, 2'b01);
    @(negedge clk_i);
    chk("s3_done", bus.lane_done_o, 2'b01);
    chk("s3_illegal", bus.lane_illegal_o[0], 1);
    chk("s3_instr", bus.lane_instr_o[15:0], 16'h6000);
    step();
    ack_and_drop(2'b01);

    // Two pending lanes are served in order.
    lanes(2'b11, 32'h0000_6000, 32'h0000_A002, 2'b11, 2'b11);
    step();
    wait_req("s4_req0");
    chk("s4_instr0", bus.cmp_instr_o, 16'h6000);
    respond(1, 32'h1111_1111, 2'b00);
    @(negedge clk_i);
    chk("s4_done_first", bus.lane_done_o, 2'b01);
    chk("s4_stall_first", bus.stall_o, 1);
    wait_req("s4_req1");
    chk("s4_instr1", bus.cmp_instr_o, 16'hA002);
    respond(1, 32'h2222_2222, 2'b00);
    @(negedge clk_i);
    chk("s4_done_both", bus.lane_done_o, 2'b11);
    chk("s4_stall_both", bus.stall_o, 0);
    chk("s4_results", bus.lane_instr_o, 64'h2222_2222_1111_1111);
    step();
    ack_and_drop(2'b11);

    // Flush while the request is open: valid held until ready, response dropped.
    lanes(2'b01, 32'h0000_6000, 32'h0, 2'b01, 2'b01);
    step();
    bus.flush_i = 1;
    @(negedge clk_i);
    chk("s5_stall_flush", bus.stall_o, 0);
    step();
    bus.flush_i = 0;
    lanes(2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
    chk("s5_valid_c2", bus.cmp_valid_o, 1);
    step();
    chk("s5_valid_c3", bus.cmp_valid_o, 1);
    step();
    chk("s5_valid_c4", bus.cmp_valid_o, 1);
    respond(1, 32'h3333_3333, 2'b00);
    @(negedge clk_i);
    chk("s5_valid_end", bus.cmp_valid_o, 0);
    chk("s5_no_done", bus.lane_done_o, 0);
    chk("s5_state_idle", state, 0);
    step();

    // Lane dropped while granted: response discarded.
    lanes(2'b01, 32'h0000_6000, 32'h0, 2'b01, 2'b01);
    step();
    lanes(2'b00, 32'h0000_6000, 32'h0, 2'b01, 2'b01);
    step();
    respond(1, 32'h4444_4444, 2'b00);
    @(negedge clk_i);
    chk("s8_no_done", bus.lane_done_o, 0);
    step();

`ifdef CVXIF_CMP_TIMEOUT_EN
    // No ready at all: forced illegal after TO request cycles, valid still held.
    lanes(2'b01, 32'h0000_6000, 32'h0, 2'b01, 2'b01);
    for (int k = 0; k < 5; k++) step();
    @(negedge clk_i);
    chk("s7_done", bus.lane_done_o, 2'b01);
    chk("s7_illegal", bus.lane_illegal_o[0], 1);
    chk("s7_instr", bus.lane_instr_o[15:0], 16'h6000);
    chk("s7_valid_held", bus.cmp_valid_o, 1);
    step();
    bus.lane_valid_i = '0;
    respond(1, 32'h5555_5555, 2'b01);
    @(negedge clk_i);
    chk("s7_drained", bus.cmp_valid_o, 0);
    step();
`endif

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
